key_unlock_seq: RTL and testbench

Sequencer that unlocks a key-locked benchmark FSM. It holds the locked core in reset and fetches a KEY_W-bit key serially from the on-chip key store over a valid/ready handshake. It checks the key's parity, then drives the parallel key input and releases the core. Repeated fetch failures latch a permanent lockout that only reset clears.

---
 rtl/key_lock_pkg.sv | 25 ++
 rtl/key_shift_reg.sv | 47 ++++
 rtl/key_unlock_seq.sv | 129 ++++++++++++
 tb/tb_key_unlock_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_lock_pkg.sv
// Shared types and defaults for the key-locked benchmark wrappers.
package key_lock_pkg;

  localparam int unsigned KEY_W_DEF     = 8;
  localparam int unsigned MAX_TRIES_DEF = 3;
  localparam int unsigned TIMEOUT_DEF   = 255;

  // Widest key the parity helper covers; narrower keys are zero-extended.
  localparam int unsigned PAR_W_MAX = 256;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    RUN,
    FAIL,
    LOCK
  } state_e;

  // Zero-extension leaves the XOR reduction unchanged.
  function automatic logic parity(input logic [PAR_W_MAX-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Serial key capture: KEY_W data bits MSB first, then one parity bit.
module key_shift_reg #(
  parameter int unsigned KEY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             accept_i,
  input  logic             data_i,
  output logic [KEY_W-1:0] sh_o,
  output logic             par_o,
  output logic             done_c
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [KEY_W-1:0] sh_q;
  logic             par_q;
  logic             last_c;

  // The bit arriving at count KEY_W is the parity bit.
  assign last_c = (cnt_q == CNT_W'(KEY_W));
  assign done_c = accept_i & last_c;
  assign sh_o   = sh_q;
  assign par_o  = par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sh_q  <= '0;
      par_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
      sh_q  <= '0;
      par_q <= 1'b0;
    end else if (accept_i) begin
      if (last_c) begin
        par_q <= data_i;
      end else begin
        sh_q <= KEY_W'({sh_q, data_i});
      end
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_unlock_seq.sv
// Unlock sequencer: fetches a serial key, checks parity, then releases the locked core.
module key_unlock_seq
  import key_lock_pkg::*;
#(
  parameter int unsigned KEY_W     = KEY_W_DEF,
  parameter int unsigned MAX_TRIES = MAX_TRIES_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kv_valid,
  input  logic             kv_data,
  output logic             kv_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             core_rst,
  output logic             key_ok,
  output logic             lockout,
  output logic             busy
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned TR_W = $clog2(MAX_TRIES + 1);

  state_e           state_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [TR_W-1:0]  tries_q;

  logic [KEY_W-1:0] sh;
  logic             par;
  logic             done_c;
  logic             accept_c;
  logic             clr_c;
  logic             key_good_c;
  logic [TO_W-1:0]  to_inc_c;
  logic [TR_W-1:0]  tries_inc_c;

  assign accept_c    = kv_valid & kv_ready;
  assign clr_c       = start & ((state_q == IDLE) | (state_q == RUN));
  assign key_good_c  = (parity(PAR_W_MAX'(sh)) ^ par) == 1'b0;
  assign to_inc_c    = (to_cnt_q == TO_W'(TIMEOUT)) ? to_cnt_q : to_cnt_q + TO_W'(1);
  assign tries_inc_c = tries_q + TR_W'(1);

  key_shift_reg #(
    .KEY_W (KEY_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr_c),
    .accept_i (accept_c),
    .data_i   (kv_data),
    .sh_o     (sh),
    .par_o    (par),
    .done_c   (done_c)
  );

  // Outputs are updated alongside the state so each one reflects the state it enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
      tries_q  <= '0;
      key_out  <= '0;
      core_rst <= 1'b1;
      kv_ready <= 1'b0;
      key_ok   <= 1'b0;
      lockout  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (start) begin
            state_q  <= SHIFT;
            to_cnt_q <= '0;
            core_rst <= 1'b1;
            key_ok   <= 1'b0;
            kv_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          if (accept_c) begin
            to_cnt_q <= '0;
            if (done_c) begin
              state_q  <= CHECK;
              kv_ready <= 1'b0;
            end
          end else begin
            to_cnt_q <= to_inc_c;
            if (to_inc_c == TO_W'(TIMEOUT)) begin
              state_q  <= FAIL;
              kv_ready <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end
        CHECK: begin
          busy <= 1'b0;
          if (key_good_c) begin
            state_q  <= RUN;
            key_out  <= sh;
            tries_q  <= '0;
            core_rst <= 1'b0;
            key_ok   <= 1'b1;
          end else begin
            state_q <= FAIL;
          end
        end
        FAIL: begin
          tries_q <= tries_inc_c;
          if (tries_inc_c == TR_W'(MAX_TRIES)) begin
            state_q <= LOCK;
            lockout <= 1'b1;
            key_out <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        LOCK: begin
          state_q <= LOCK;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_unlock_seq.sv
// Directed bench for key_unlock_seq with a scoreboard of expected fetch outcomes.
module tb_key_unlock_seq;

  localparam int unsigned KW = 8;
  localparam int unsigned TO = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          kv_valid = 1'b0;
  logic          kv_data = 1'b0;
  logic          kv_ready;
  logic [KW-1:0] key_out;
  logic          core_rst;
  logic          key_ok;
  logic          lockout;
  logic          busy;

  int tests = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit            ok;
    logic [KW-1:0] key;
    int            when;
  } exp_t;

  exp_t sb[$];

  key_unlock_seq #(
    .KEY_W     (KW),
    .MAX_TRIES (3),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .kv_valid (kv_valid),
    .kv_data  (kv_data),
    .kv_ready (kv_ready),
    .key_out  (key_out),
    .core_rst (core_rst),
    .key_ok   (key_ok),
    .lockout  (lockout),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit ok, input logic [KW-1:0] key, input int when);
    exp_t e;
    e.ok   = ok;
    e.key  = key;
    e.when = when;
    sb.push_back(e);
  endtask

  // Start is sampled at the first negedge's following posedge; returns in the first SHIFT cycle.
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends the top n bits of v (key MSB first, parity in v[0]); plast = cycle of last transfer.
  task automatic send_bits(input logic [8:0] v, input int n, input bit gap, output int plast);
    plast = cyc;
    for (int i = 0; i < n; i++) begin
      kv_valid = 1'b1;
      kv_data  = v[8-i];
      chk("kv_ready_shift", 32'(kv_ready), 32'd1);
      plast = cyc;
      @(negedge clk);
      if (gap && i != n - 1) begin
        kv_valid = 1'b0;
        chk("kv_ready_gap", 32'(kv_ready), 32'd1);
        @(negedge clk);
      end
    end
    kv_valid = 1'b0;
  endtask

  task automatic good_key(input logic [8:0] v, input logic [KW-1:0] key, input bit gap);
    int p;
    start_pulse();
    send_bits(v, 9, gap, p);
    push(1'b1, key, p + 2);
    repeat (2) @(negedge clk);
    chk("run_core_rst", 32'(core_rst), 32'd0);
    chk("run_key_ok", 32'(key_ok), 32'd1);
  endtask

  task automatic bad_key(input logic [KW-1:0] held);
    int p;
    start_pulse();
    send_bits(9'h165, 9, 1'b0, p);
    push(1'b0, held, p + 2);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every end of a fetch (busy falling outside reset) must match the oldest expectation.
  initial begin
    logic busy_prev;
    exp_t e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && busy_prev && !busy) begin
        if (sb.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_outcome: key_ok=%0d key_out=0x%0h at cycle %0d", key_ok, key_out, cyc);
        end else begin
          e = sb.pop_front();
          chk("outcome_key_ok", 32'(key_ok), 32'(e.ok));
          chk("outcome_core_rst", 32'(core_rst), e.ok ? 32'd0 : 32'd1);
          chk("outcome_key_out", 32'(key_out), 32'(e.key));
          chk("outcome_lockout", 32'(lockout), 32'd0);
          chk("outcome_cycle", 32'(cyc), 32'(e.when));
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    int p;

    // Reset values
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_key_out", 32'(key_out), 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_kv_ready", 32'(kv_ready), 32'd0);
    chk("rst_key_ok", 32'(key_ok), 32'd0);
    chk("rst_lockout", 32'(lockout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good key 8'hB2, continuous valid
    good_key(9'h164, 8'hB2, 1'b0);

    // Re-key from RUN to 8'h5A
    start_pulse();
    chk("rekey_core_rst", 32'(core_rst), 32'd1);
    chk("rekey_key_ok", 32'(key_ok), 32'd0);
    chk("rekey_key_held", 32'(key_out), 32'hB2);
    chk("rekey_busy", 32'(busy), 32'd1);
    send_bits(9'h0B4, 9, 1'b0, p);
    push(1'b1, 8'h5A, p + 2);
    repeat (2) @(negedge clk);
    chk("rekey_key_out", 32'(key_out), 32'h5A);

    // Gapped valid, same key as continuous case
    good_key(9'h164, 8'hB2, 1'b1);

    // Bad parity three times -> lockout
    bad_key(8'hB2);
    chk("bad1_idle_core_rst", 32'(core_rst), 32'd1);
    chk("bad1_lockout", 32'(lockout), 32'd0);
    bad_key(8'hB2);
    chk("bad2_lockout", 32'(lockout), 32'd0);
    bad_key(8'hB2);
    chk("lock_lockout", 32'(lockout), 32'd1);
    chk("lock_key_out", 32'(key_out), 32'd0);
    chk("lock_core_rst", 32'(core_rst), 32'd1);
    start_pulse();
    repeat (3) @(negedge clk);
    chk("lock_start_kv_ready", 32'(kv_ready), 32'd0);
    chk("lock_start_busy", 32'(busy), 32'd0);
    chk("lock_held", 32'(lockout), 32'd1);
    chk("lock_start_core_rst", 32'(core_rst), 32'd1);

    // Reset clears lockout; then timeout after three bits
    pulse_rst();
    chk("unlock_lockout", 32'(lockout), 32'd0);
    start_pulse();
    send_bits(9'h164, 3, 1'b0, p);
    push(1'b0, 8'h00, p + TO + 1);
    while (cyc < p + TO + 2) @(negedge clk);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_kv_ready", 32'(kv_ready), 32'd0);

    // Good key clears tries: two further failures must not lock
    good_key(9'h164, 8'hB2, 1'b0);
    bad_key(8'hB2);
    bad_key(8'hB2);
    chk("tries_cleared_lockout", 32'(lockout), 32'd0);
    good_key(9'h0B4, 8'h5A, 1'b0);

    // Async reset mid-fetch, then a clean fetch
    start_pulse();
    send_bits(9'h164, 4, 1'b0, p);
    #2 rst = 1'b1;
    #1;
    chk("midrst_key_out", 32'(key_out), 32'd0);
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
    chk("midrst_kv_ready", 32'(kv_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_key_ok", 32'(key_ok), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    good_key(9'h0B4, 8'h5A, 1'b0);
    chk("after_rst_key_out", 32'(key_out), 32'h5A);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
